// File: rtl/vector_pkg.sv
// Shared constants, FSM state type and word packing for the vector display list.
// Word layout: y[17:10] | x[9:2] | END[1] | LINE[0].
package vector_pkg;

  localparam int DAC_WIDTH    = 8;
  localparam int ADDRESSWIDTH = 10;
  localparam int DATAWIDTH    = 18;

  localparam int X_LSB    = 2;
  localparam int Y_LSB    = 10;
  localparam int END_BIT  = 1;
  localparam int LINE_BIT = 0;
  localparam int VEC_W    = Y_LSB + DAC_WIDTH;

  typedef enum logic [1:0] {
    FILL,
    DROP,
    BLANK,
    WAIT_SWAP
  } vwr_state_t;

  function automatic logic [VEC_W-1:0] pack_vector(
    input logic [DAC_WIDTH-1:0] x,
    input logic [DAC_WIDTH-1:0] y,
    input logic                 line,
    input logic                 last
  );
    logic [VEC_W-1:0] w;
    w                        = '0;
    w[Y_LSB +: DAC_WIDTH]    = y;
    w[X_LSB +: DAC_WIDTH]    = x;
    w[END_BIT]               = last;
    w[LINE_BIT]              = line;
    return w;
  endfunction

endpackage

// File: rtl/vector_frame_writer.sv
// Packs a valid/ready point stream into one half of a double-buffered vector RAM
// and swaps halves on the display's frame_drawn pulse.
// Ports: clk, rst (sync, active-high); pt_valid/pt_ready/pt_x/pt_y/pt_line/pt_last
// point stream in; frame_drawn from display; wr_en/wr_addr/wr_data RAM write port;
// rd_bank selects the half the display replays; overflow is sticky.
// Optional macro VECTOR_WR_BLANK_EN: append a blanked move-to-origin END word to
// every frame (last user word then carries END=0).
module vector_frame_writer #(
  parameter int ADDRESSWIDTH = vector_pkg::ADDRESSWIDTH,
  parameter int DATAWIDTH    = vector_pkg::DATAWIDTH,
  parameter int DAC_WIDTH    = vector_pkg::DAC_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pt_valid,
  output logic                    pt_ready,
  input  logic [DAC_WIDTH-1:0]    pt_x,
  input  logic [DAC_WIDTH-1:0]    pt_y,
  input  logic                    pt_line,
  input  logic                    pt_last,
  input  logic                    frame_drawn,
  output logic                    wr_en,
  output logic [ADDRESSWIDTH-1:0] wr_addr,
  output logic [DATAWIDTH-1:0]    wr_data,
  output logic                    rd_bank,
  output logic                    overflow
);

  import vector_pkg::*;

  localparam int LW = ADDRESSWIDTH - 1;

  // Last local address a user word may occupy; the blank build keeps one
  // slot back for the trailing origin word.
`ifdef VECTOR_WR_BLANK_EN
  localparam int CAP_I = (1 << LW) - 2;
`else
  localparam int CAP_I = (1 << LW) - 1;
`endif
  localparam logic [LW-1:0] CAP = LW'(CAP_I);

  vwr_state_t               state_q, state_d;
  logic [LW-1:0]            local_q, local_d;
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic                     ovf_q, ovf_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDRESSWIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DATAWIDTH-1:0]     wr_data_q, wr_data_d;
`ifdef VECTOR_WR_BLANK_EN
  logic                     drop_q, drop_d;
`endif

  logic accept;
  logic full;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      local_q   <= '0;
      wr_bank_q <= 1'b1;
      rd_bank_q <= 1'b0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef VECTOR_WR_BLANK_EN
      drop_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      local_q   <= local_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef VECTOR_WR_BLANK_EN
      drop_q    <= drop_d;
`endif
    end
  end

  // Output logic
  always_comb begin
    pt_ready = 1'b0;
    if (!rst) begin
      pt_ready = (state_q == FILL) || (state_q == DROP);
    end
  end

  assign accept   = pt_valid && pt_ready;
  assign full     = (local_q == CAP);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_bank  = rd_bank_q;
  assign overflow = ovf_q;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    local_d   = local_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef VECTOR_WR_BLANK_EN
    drop_d    = drop_q;
`endif
    unique case (state_q)
      FILL: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {wr_bank_q, local_q};
          local_d   = local_q + LW'(1);
`ifdef VECTOR_WR_BLANK_EN
          wr_data_d = DATAWIDTH'(pack_vector(pt_x, pt_y, pt_line, 1'b0));
          drop_d    = !pt_last;
          if (pt_last || full) begin
            state_d = BLANK;
          end
          if (full && !pt_last) begin
            ovf_d = 1'b1;
          end
`else
          // A full half forces END so the display never runs off the bank.
          wr_data_d = DATAWIDTH'(pack_vector(pt_x, pt_y, pt_line,
                                             pt_last || full));
          if (pt_last) begin
            state_d = WAIT_SWAP;
          end else if (full) begin
            ovf_d   = 1'b1;
            state_d = DROP;
          end
`endif
        end
      end
      DROP: begin
        if (accept && pt_last) begin
          state_d = WAIT_SWAP;
        end
      end
      BLANK: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {wr_bank_q, local_q};
        wr_data_d = DATAWIDTH'(pack_vector('0, '0, 1'b0, 1'b1));
        local_d   = local_q + LW'(1);
`ifdef VECTOR_WR_BLANK_EN
        state_d   = drop_q ? DROP : WAIT_SWAP;
`else
        state_d   = WAIT_SWAP;
`endif
      end
      WAIT_SWAP: begin
        if (frame_drawn) begin
          rd_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
          local_d   = '0;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

endmodule
